equiv_sequencer: RTL

//  Sequential stimulus/compare controller for checking two implementations of the same
//  N-input combinational function (e.g. gate-level vs expression form) against each other.

---
 rtl/equiv_sequencer.sv | 108 ++++++++++
 1 files changed

// File: rtl/equiv_sequencer.sv
// Stimulus/compare controller: steps x through all 2^N vectors, lets each settle,
// then counts a_in/b_in disagreements and remembers the first failing vector.
module equiv_sequencer #(
  parameter int N      = 2,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [N-1:0] x,
  input  logic         a_in,
  input  logic         b_in,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic         fail_valid,
  output logic [N-1:0] first_fail
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [N-1:0]  x_reg, x_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [N:0]    err_reg, err_next;
  logic          fv_reg, fv_next;
  logic [N-1:0]  ff_reg, ff_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      x_reg     <= '0;
      cnt_reg   <= '0;
      err_reg   <= '0;
      fv_reg    <= 1'b0;
      ff_reg    <= '0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
      fv_reg    <= fv_next;
      ff_reg    <= ff_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    fv_next    = fv_reg;
    ff_next    = ff_reg;
    case (state_reg)
      IDLE, DONE: begin
        // A restart from DONE clears the previous result set.
        if (start) begin
          state_next = WAIT;
          x_next     = '0;
          cnt_next   = CNT_LOAD;
          err_next   = '0;
          fv_next    = 1'b0;
          ff_next    = '0;
        end
      end
      WAIT: begin
        if (cnt_reg == '0) state_next = CHECK;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      CHECK: begin
        if (a_in != b_in) begin
          err_next = err_reg + 1'b1;
          if (!fv_reg) begin
            fv_next = 1'b1;
            ff_next = x_reg;
          end
        end
        if (x_reg == '1) begin
          state_next = DONE;
        end else begin
          state_next = WAIT;
          x_next     = x_reg + 1'b1;
          cnt_next   = CNT_LOAD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Status flags decode directly from registered state, so pass moves with done.
  assign x          = x_reg;
  assign busy       = (state_reg == WAIT) || (state_reg == CHECK);
  assign done       = (state_reg == DONE);
  assign pass       = (state_reg == DONE) && (err_reg == '0);
  assign err_count  = err_reg;
  assign fail_valid = fv_reg;
  assign first_fail = ff_reg;

endmodule
